// File: rtl/svm_param_loader.sv
// svm_param_loader
//   Receives one SVM model (support vectors, dual coefficients, bias) as a
//   stream of signed words into a shadow bank. The bank is copied to the
//   active outputs in a single edge once the load has framed correctly and
//   the consumer is not mid-inference. The active bank therefore only ever
//   holds a complete model.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous, active-high reset
//   s_valid        stream word valid
//   s_ready        loader can accept a word (low during reset and while
//                  a commit is pending)
//   s_data         signed parameter word
//   s_last         marks the final (bias) word of a load
//   commit_hold    consumer busy; blocks only the shadow->active copy
//   sv_flat        active support vectors, word n = j*NF + i
//   dual_coef_flat active dual coefficients, word j
//   bias           active bias
//   params_valid   high once any load has committed
//   load_done      one-cycle pulse on commit
//   load_error     sticky framing error, cleared by the next load's first word
//
// FSM states
//   state       | meaning
//   IDLE        | no load in progress, next word is SV word 0
//   LOAD_SV     | receiving support-vector words
//   LOAD_COEF   | receiving dual-coefficient words
//   LOAD_BIAS   | next word is the bias and must carry s_last
//   COMMIT_WAIT | shadow complete, waiting for commit_hold low
//   DRAIN       | framing lost, discarding words up to the next s_last
module svm_param_loader #(
  parameter int DATA_WIDTH          = 16,
  parameter int NUM_FEATURES        = 16,
  parameter int NUM_SUPPORT_VECTORS = 16
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   s_valid,
  output logic                                                   s_ready,
  input  logic [DATA_WIDTH-1:0]                                  s_data,
  input  logic                                                   s_last,
  input  logic                                                   commit_hold,
  output logic [DATA_WIDTH*NUM_FEATURES*NUM_SUPPORT_VECTORS-1:0] sv_flat,
  output logic [DATA_WIDTH*NUM_SUPPORT_VECTORS-1:0]              dual_coef_flat,
  output logic [DATA_WIDTH-1:0]                                  bias,
  output logic                                                   params_valid,
  output logic                                                   load_done,
  output logic                                                   load_error
);

  localparam int SV_WORDS   = NUM_FEATURES * NUM_SUPPORT_VECTORS;
  localparam int COEF_END   = SV_WORDS + NUM_SUPPORT_VECTORS;
  localparam int LOAD_WORDS = COEF_END + 1;
  localparam int CNT_W      = $clog2(LOAD_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_SV,
    LOAD_COEF,
    LOAD_BIAS,
    COMMIT_WAIT,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;

  logic [DATA_WIDTH*SV_WORDS-1:0]            shadow_sv;
  logic [DATA_WIDTH*NUM_SUPPORT_VECTORS-1:0] shadow_coef;
  logic [DATA_WIDTH-1:0]                     shadow_bias;

  logic accept;
  logic cnt_clr, cnt_inc;
  logic wr_sv, wr_coef, wr_bias;
  logic err_set, err_clr;
  logic do_commit;
  int   sv_lsb, coef_lsb;

  // s_ready is combinational so it is low for exactly as long as rst is high.
  assign s_ready = !rst && (state != COMMIT_WAIT);
  assign accept  = s_valid && s_ready;

  always_comb begin
    sv_lsb   = int'(cnt) * DATA_WIDTH;
    coef_lsb = (int'(cnt) - SV_WORDS) * DATA_WIDTH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    wr_sv     = 1'b0;
    wr_coef   = 1'b0;
    wr_bias   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    do_commit = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          wr_sv   = 1'b1;
          err_clr = 1'b1;
          if (s_last) begin
            // A one-word "load" is a framing error; counter is already 0.
            err_set = 1'b1;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = (SV_WORDS == 1) ? LOAD_COEF : LOAD_SV;
          end
        end
      end

      LOAD_SV: begin
        if (accept) begin
          wr_sv = 1'b1;
          if (s_last) begin
            err_set   = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_inc = 1'b1;
            if (cnt == CNT_W'(SV_WORDS - 1)) begin
              state_nxt = LOAD_COEF;
            end
          end
        end
      end

      LOAD_COEF: begin
        if (accept) begin
          wr_coef = 1'b1;
          if (s_last) begin
            err_set   = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_inc = 1'b1;
            if (cnt == CNT_W'(COEF_END - 1)) begin
              state_nxt = LOAD_BIAS;
            end
          end
        end
      end

      LOAD_BIAS: begin
        // Counter sits at LOAD_WORDS-1 from here on, so it never wraps.
        if (accept) begin
          if (s_last) begin
            wr_bias   = 1'b1;
            state_nxt = COMMIT_WAIT;
          end else begin
            // The shadow bank is simply never committed; the next load
            // overwrites every word of it.
            err_set   = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end

      COMMIT_WAIT: begin
        if (!commit_hold) begin
          do_commit = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end

      DRAIN: begin
        if (accept && s_last) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      shadow_sv      <= '0;
      shadow_coef    <= '0;
      shadow_bias    <= '0;
      sv_flat        <= '0;
      dual_coef_flat <= '0;
      bias           <= '0;
      params_valid   <= 1'b0;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      load_done <= 1'b0;

      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (wr_sv) begin
        shadow_sv[sv_lsb +: DATA_WIDTH] <= s_data;
      end
      if (wr_coef) begin
        shadow_coef[coef_lsb +: DATA_WIDTH] <= s_data;
      end
      if (wr_bias) begin
        shadow_bias <= s_data;
      end

      // Set wins so a first word that also carries s_last stays flagged.
      if (err_set) begin
        load_error <= 1'b1;
      end else if (err_clr) begin
        load_error <= 1'b0;
      end

      if (do_commit) begin
        sv_flat        <= shadow_sv;
        dual_coef_flat <= shadow_coef;
        bias           <= shadow_bias;
        params_valid   <= 1'b1;
        load_done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svm_param_loader.sv
module tb_svm_param_loader;

  localparam int DW  = 16;
  localparam int NF  = 16;
  localparam int NSV = 16;
  localparam int SVW = NF * NSV;
  localparam int L   = SVW + NSV + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_valid;
  logic                  s_ready;
  logic [DW-1:0]         s_data;
  logic                  s_last;
  logic                  commit_hold;
  logic [DW*SVW-1:0]     sv_flat;
  logic [DW*NSV-1:0]     dual_coef_flat;
  logic [DW-1:0]         bias;
  logic                  params_valid;
  logic                  load_done;
  logic                  load_error;

  svm_param_loader #(
    .DATA_WIDTH(DW),
    .NUM_FEATURES(NF),
    .NUM_SUPPORT_VECTORS(NSV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .commit_hold(commit_hold),
    .sv_flat(sv_flat),
    .dual_coef_flat(dual_coef_flat),
    .bias(bias),
    .params_valid(params_valid),
    .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*SVW-1:0] sv;
    logic [DW*NSV-1:0] coef;
    logic [DW-1:0]     bias;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   commit_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Word k of a load (1-based) carries k + off.
  function automatic exp_t make_exp(input int off);
    exp_t e;
    for (int n = 0; n < SVW; n++) e.sv[n*DW +: DW] = DW'(n + 1 + off);
    for (int j = 0; j < NSV; j++) e.coef[j*DW +: DW] = DW'(SVW + 1 + j + off);
    e.bias = DW'(L + off);
    return e;
  endfunction

  // Monitor: every load_done pulse is a commit; compare against the oldest
  // expected model.
  initial begin
    exp_t e;
    int   m;
    bit   found;
    forever begin
      @(negedge clk);
      if (load_done === 1'b1) begin
        commit_count++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit: got commit with bias %0d expected no commit", bias);
        end else begin
          e = sb_q.pop_front();
          m = 0;
          found = 1'b0;
          for (int n = 0; n < SVW; n++)
            if (!found && sv_flat[n*DW +: DW] !== e.sv[n*DW +: DW]) begin
              m = n;
              found = 1'b1;
            end
          chk($sformatf("commit_sv_word%0d", m), int'(sv_flat[m*DW +: DW]), int'(e.sv[m*DW +: DW]));
          m = 0;
          found = 1'b0;
          for (int j = 0; j < NSV; j++)
            if (!found && dual_coef_flat[j*DW +: DW] !== e.coef[j*DW +: DW]) begin
              m = j;
              found = 1'b1;
            end
          chk($sformatf("commit_coef%0d", m), int'(dual_coef_flat[m*DW +: DW]), int'(e.coef[m*DW +: DW]));
          chk("commit_bias", int'(bias), int'(e.bias));
          chk("commit_params_valid", int'(params_valid), 1);
        end
      end
    end
  end

  // Send n_words words; s_last on word last_at (0 = never). gap=1 inserts
  // random idle cycles. stalls counts cycles where s_valid met s_ready=0.
  task automatic send_load(input int off, input int n_words, input int last_at,
                           input bit gap, output int stalls);
    int k;
    int cyc;
    bit v;
    bit rdy;
    k = 0;
    cyc = 0;
    stalls = 0;
    while (k < n_words && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      v = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = v;
      s_data  = DW'(k + 1 + off);
      s_last  = (k + 1 == last_at);
      rdy     = s_ready;
      if (v && !rdy) stalls++;
      @(posedge clk);
      #1;
      if (v && rdy) k++;
      if (k == n_words) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
    end
    chk("send_words_accepted", k, n_words);
  endtask

  task automatic wait_commit(input int exp_count);
    for (int i = 0; i < 40; i++) begin
      if (commit_count >= exp_count) break;
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("commit_count", commit_count, exp_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    commit_hold = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_sv0", int'(sv_flat[DW-1:0]), 0);
    chk("rst_bias", int'(bias), 0);
    chk("rst_params_valid", int'(params_valid), 0);
    chk("rst_load_error", int'(load_error), 0);
    chk("rst_load_done", int'(load_done), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", int'(s_ready), 1);

    // full load, s_valid held high
    sb_q.push_back(make_exp(0));
    send_load(0, L, L, 1'b0, st);
    chk("full_stalls", st, 0);
    wait_commit(1);
    chk("full_params_valid", int'(params_valid), 1);
    chk("full_bias", int'(bias), 273);
    chk("full_coef0", int'(dual_coef_flat[DW-1:0]), 257);
    chk("full_load_error", int'(load_error), 0);

    // commit_hold for 5 cycles after the bias word
    commit_hold = 1'b1;
    sb_q.push_back(make_exp(1000));
    send_load(1000, L, L, 1'b0, st);
    chk("hold_load_stalls", st, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_s_ready", int'(s_ready), 0);
      chk("hold_bias_unchanged", int'(bias), 273);
      chk("hold_no_commit", commit_count, 1);
    end
    commit_hold = 1'b0;
    @(negedge clk);
    #1;
    chk("commit_on_release", commit_count, 2);
    chk("hold_bias", int'(bias), 1273);

    // early s_last on word 100
    send_load(2000, 100, 100, 1'b0, st);
    @(negedge clk);
    #1;
    chk("early_load_error", int'(load_error), 1);
    chk("early_s_ready", int'(s_ready), 1);
    chk("early_bias_intact", int'(bias), 1273);
    chk("early_sv0_intact", int'(sv_flat[DW-1:0]), 1001);
    chk("early_no_commit", commit_count, 2);

    // missing s_last on bias word, given on word 276
    send_load(3000, L + 3, L + 3, 1'b0, st);
    chk("drain_stalls", st, 0);
    @(negedge clk);
    #1;
    chk("drain_load_error", int'(load_error), 1);
    chk("drain_bias_intact", int'(bias), 1273);
    chk("drain_no_commit", commit_count, 2);
    sb_q.push_back(make_exp(4000));
    send_load(4000, L, L, 1'b0, st);
    chk("recover_load_error", int'(load_error), 0);
    wait_commit(3);
    chk("recover_bias", int'(bias), 4273);

    // random s_valid gaps
    sb_q.push_back(make_exp(0));
    send_load(0, L, L, 1'b1, st);
    chk("gap_stalls", st, 0);
    wait_commit(4);
    chk("gap_bias", int'(bias), 273);

    // reset in the middle of a load
    send_load(5000, 150, 0, 1'b0, st);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_s_ready", int'(s_ready), 0);
    chk("midrst_sv0", int'(sv_flat[DW-1:0]), 0);
    chk("midrst_coef0", int'(dual_coef_flat[DW-1:0]), 0);
    chk("midrst_bias", int'(bias), 0);
    chk("midrst_params_valid", int'(params_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_release_s_ready", int'(s_ready), 1);
    sb_q.push_back(make_exp(6000));
    send_load(6000, L, L, 1'b0, st);
    chk("postrst_stalls", st, 0);
    wait_commit(5);
    chk("postrst_params_valid", int'(params_valid), 1);
    chk("postrst_bias", int'(bias), 6273);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
